// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that locks a UART TX byte stream to one requester
// until end-of-packet or a burst limit, with a one-deep output register.
module uart_tx_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned MAX_BURST  = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_PORTS-1:0]            s_valid,
  input  logic [NUM_PORTS-1:0]            s_last,
  output logic [NUM_PORTS-1:0]            s_ready,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [$clog2(NUM_PORTS)-1:0]    grant_id,
  output logic                            active
);

  localparam int unsigned GW = $clog2(NUM_PORTS);
  localparam int unsigned CW = 16;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [GW-1:0]         grant_d;
  logic [CW-1:0]         burst_q, burst_d;
  logic [DATA_WIDTH-1:0] m_data_d;
  logic                  m_valid_d;

  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  out_free;
  logic                  accept;
  logic                  burst_done;

  logic [2*NUM_PORTS-1:0] rr_dbl;
  logic [NUM_PORTS-1:0]   rr_rot;
  logic [GW:0]            rr_start;
  logic [GW:0]            rr_off;
  logic [GW+1:0]          rr_sum;
  logic                   rr_found;
  logic [GW-1:0]          rr_pick;

  assign active = (state_q == LOCKED);

  // Grantee's request lines
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (grant_id == GW'(i)) begin
        sel_data  = s_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_valid = s_valid[i];
        sel_last  = s_last[i];
      end
    end
  end

  // Rotate requests so bit 0 is port (grant_id+1), take the first set bit, map back
  always_comb begin
    rr_start = {1'b0, grant_id} + (GW+1)'(1);
    rr_dbl   = {s_valid, s_valid} >> rr_start;
    rr_rot   = rr_dbl[NUM_PORTS-1:0];
    rr_off   = '0;
    rr_found = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!rr_found && rr_rot[i]) begin
        rr_found = 1'b1;
        rr_off   = (GW+1)'(i);
      end
    end
    rr_sum = {1'b0, rr_start} + {1'b0, rr_off};
    if (rr_sum >= (GW+2)'(NUM_PORTS)) begin
      rr_sum = rr_sum - (GW+2)'(NUM_PORTS);
    end
    rr_pick = rr_sum[GW-1:0];
  end

  // Next-state, handshake and output-register logic
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_id;
    burst_d    = burst_q;
    m_valid_d  = m_valid;
    m_data_d   = m_data;
    s_ready    = '0;
    out_free   = !m_valid || m_ready;
    accept     = 1'b0;
    burst_done = (({1'b0, burst_q} + (CW+1)'(1)) == (CW+1)'(MAX_BURST));

    if (m_valid && m_ready) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (rr_found) begin
          grant_d = rr_pick;
          burst_d = '0;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
          if (grant_id == GW'(i)) begin
            s_ready[i] = out_free;
          end
        end
        accept = sel_valid && out_free;
        if (accept) begin
          m_valid_d = 1'b1;
          m_data_d  = sel_data;
          burst_d   = burst_q + CW'(1);
          if (sel_last || burst_done) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset points grant_id at the last port so the first search starts at port 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_id <= GW'(NUM_PORTS - 1);
      burst_q  <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
    end else begin
      state_q  <= state_d;
      grant_id <= grant_d;
      burst_q  <= burst_d;
      m_valid  <= m_valid_d;
      m_data   <= m_data_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-port packet queues drive the
// requesters, a packet-level arbitration model predicts grants and bytes.
module tb_uart_tx_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned NP = 4;
  localparam int unsigned MB = 4;
  localparam int unsigned GW = 2;

  logic            clk;
  logic            rst;
  logic [NP*DW-1:0] s_data;
  logic [NP-1:0]   s_valid;
  logic [NP-1:0]   s_last;
  logic [NP-1:0]   s_ready;
  logic [DW-1:0]   m_data;
  logic            m_valid;
  logic            m_ready;
  logic [GW-1:0]   grant_id;
  logic            active;

  uart_tx_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .MAX_BURST(MB)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .grant_id (grant_id),
    .active   (active)
  );

  typedef struct {
    int         port;
    logic [7:0] data;
    bit         last;
  } item_t;

  item_t      load_q[$];
  item_t      drv_q[NP][$];
  item_t      mdl_q[NP][$];
  logic [7:0] exp_q[$];
  int         exp_grant[$];

  int errors = 0;
  int checks = 0;

  bit rst_req    = 1'b1;
  int ready_mode = 1;
  int drop_pct   = 0;
  int force_len  = 0;
  int pending    = 0;
  int mdl_gid    = NP - 1;

  int          seg_pos[NP];
  int          held[NP];
  logic [NP-1:0] acc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  task automatic add(input int port, input logic [7:0] d, input bit last);
    item_t it;
    it.port = port;
    it.data = d;
    it.last = last;
    load_q.push_back(it);
    mdl_q[port].push_back(it);
  endtask

  // Packet-level model: round-robin from last grantee, each grant ends at last or MB bytes
  task automatic run_model();
    int    p;
    item_t it;
    forever begin
      p = -1;
      for (int k = 1; k <= int'(NP); k++) begin
        if (p < 0 && mdl_q[(mdl_gid + k) % NP].size() > 0) p = (mdl_gid + k) % NP;
      end
      if (p < 0) break;
      exp_grant.push_back(p);
      mdl_gid = p;
      for (int n = 0; n < int'(MB); n++) begin
        if (mdl_q[p].size() == 0) break;
        it = mdl_q[p].pop_front();
        exp_q.push_back(it.data);
        if (it.last) break;
      end
    end
  endtask

  task automatic flush_model();
    for (int p = 0; p < int'(NP); p++) mdl_q[p].delete();
    exp_q.delete();
    exp_grant.delete();
    mdl_gid = NP - 1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (n < 3000 && !(load_q.size() == 0 && pending == 0 && exp_q.size() == 0 &&
                         exp_grant.size() == 0 && !m_valid && !active)) begin
      tick();
      n++;
    end
    chk({name, "_drained"}, longint'(n < 3000), 1);
  endtask

  // Requester and UART-ready driver; only a mid-segment grantee may drop s_valid
  initial begin
    item_t it;
    bit    drop;
    rst = 1'b1; s_valid = '0; s_data = '0; s_last = '0; m_ready = 1'b0; acc = '0;
    for (int p = 0; p < int'(NP); p++) begin seg_pos[p] = 0; held[p] = 0; end
    forever begin
      @(negedge clk);
      rst = rst_req;
      if (rst_req) begin
        for (int p = 0; p < int'(NP); p++) begin
          drv_q[p].delete(); seg_pos[p] = 0; held[p] = 0;
        end
        acc = '0;
      end else begin
        for (int p = 0; p < int'(NP); p++) begin
          if (acc[p]) begin
            it = drv_q[p].pop_front();
            seg_pos[p] = (it.last || seg_pos[p] + 1 == int'(MB)) ? 0 : seg_pos[p] + 1;
            held[p] = 0;
          end
        end
      end
      while (load_q.size() > 0) begin
        it = load_q.pop_front();
        drv_q[it.port].push_back(it);
      end
      m_ready = (ready_mode == 1) ? 1'b1 : (ready_mode == 0) ? 1'b0 : ($urandom_range(99) < 70);
      pending = 0;
      for (int p = 0; p < int'(NP); p++) begin
        pending += drv_q[p].size();
        s_valid[p] = 1'b0;
        s_last[p]  = 1'b0;
        s_data[p*DW +: DW] = '0;
        if (!rst_req && drv_q[p].size() > 0) begin
          drop = 1'b0;
          if (seg_pos[p] != 0) begin
            if (seg_pos[p] == 1 && held[p] < force_len) begin
              drop = 1'b1;
              held[p]++;
            end else if ($urandom_range(99) < drop_pct) begin
              drop = 1'b1;
            end
          end
          s_valid[p] = !drop;
          s_data[p*DW +: DW] = drv_q[p][0].data;
          s_last[p]  = drv_q[p][0].last;
        end
      end
      #1 acc = s_valid & s_ready;
    end
  end

  // Monitor: output bytes, grant order and output hold under backpressure
  initial begin
    bit         pa;
    bit         stall;
    logic [7:0] pd;
    pa = 1'b0; stall = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        pa = 1'b0;
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("hold_m_valid", m_valid, 1);
          chk("hold_m_data", m_data, pd);
        end
        if (active && !pa) begin
          if (exp_grant.size() == 0) begin
            checks++; errors++;
            $display("FAIL grant_unexpected: got %0d expected none at %0t", grant_id, $time);
          end else begin
            chk("grant_order", grant_id, exp_grant.pop_front());
          end
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL byte_unexpected: got %0h expected none at %0t", m_data, $time);
          end else begin
            chk("m_data", m_data, exp_q.pop_front());
          end
        end
        stall = m_valid && !m_ready;
        pd = m_data;
        pa = active;
      end
    end
  end

  initial begin
    int hs[$];
    int cnt;
    bit seen;
    bit got_valid;

    repeat (3) tick();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_active", active, 0);
    chk("rst_grant_id", grant_id, NP - 1);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_data", m_data, 0);
    rst_req = 1'b0;
    tick();

    // Single port, three-byte packet at full rate
    ready_mode = 1;
    add(2, 8'h41, 1'b0); add(2, 8'h42, 1'b0); add(2, 8'h43, 1'b1);
    run_model();
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (m_valid && m_ready) hs.push_back(c);
      if (active && !seen) begin
        seen = 1'b1;
        chk("single_grant_id", grant_id, 2);
      end
    end
    chk("single_count", hs.size(), 3);
    if (hs.size() >= 3) chk("single_back_to_back", hs[2] - hs[0], 2);
    chk("single_active_fell", active, 0);
    drain("single");

    // Round robin over ports 0,1,3 with one-byte packets
    add(0, 8'h10, 1'b1); add(1, 8'h11, 1'b1); add(3, 8'h13, 1'b1); add(0, 8'h20, 1'b1);
    run_model();
    drain("round_robin");

    // Backpressure on a pending byte
    ready_mode = 0;
    add(0, 8'h55, 1'b0); add(0, 8'h66, 1'b1);
    run_model();
    got_valid = 1'b0;
    for (int c = 0; c < 20 && !got_valid; c++) begin
      tick();
      got_valid = m_valid;
    end
    chk("bp_m_valid_seen", got_valid, 1);
    repeat (5) begin
      tick();
      chk("bp_m_data", m_data, 8'h55);
      chk("bp_m_valid", m_valid, 1);
      chk("bp_s_ready", s_ready, 0);
    end
    ready_mode = 1;
    drain("backpressure");

    // Burst limit: ten-byte packet on port 1 interleaved with port 0
    for (int i = 0; i < 10; i++) add(1, 8'(8'h80 + i), i == 9);
    add(0, 8'hA0, 1'b1);
    run_model();
    drain("burst");

    // Grantee pauses mid-packet while another port waits
    force_len = 3;
    add(3, 8'hC0, 1'b0); add(3, 8'hC1, 1'b0); add(3, 8'hC2, 1'b0); add(3, 8'hC3, 1'b1);
    add(1, 8'hD0, 1'b1);
    run_model();
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (active && grant_id == 2'd3 && !s_valid[3]) cnt++;
    end
    chk("pause_lock_held_cycles", cnt, 3);
    force_len = 0;
    drain("pause");

    // Randomized packets, gaps and backpressure
    drop_pct = 25;
    ready_mode = 2;
    for (int k = 0; k < 60; k++) begin
      int port;
      int len;
      port = int'($urandom_range(NP - 1));
      len  = int'($urandom_range(7, 1));
      for (int i = 0; i < len; i++) add(port, 8'($urandom), i == len - 1);
    end
    run_model();
    drain("random");
    drop_pct = 0;
    ready_mode = 1;

    // Reset in the middle of a five-byte packet
    for (int i = 0; i < 5; i++) add(2, 8'(8'hE0 + i), i == 4);
    run_model();
    cnt = 0;
    for (int c = 0; c < 30 && cnt < 2; c++) begin
      tick();
      if (m_valid && m_ready) cnt++;
    end
    chk("mid_rst_bytes_before", cnt, 2);
    rst_req = 1'b1;
    tick();
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_active", active, 0);
    chk("mid_rst_grant_id", grant_id, NP - 1);
    chk("mid_rst_s_ready", s_ready, 0);
    flush_model();
    rst_req = 1'b0;
    repeat (3) tick();
    chk("post_rst_m_valid", m_valid, 0);
    add(1, 8'h71, 1'b1); add(0, 8'h70, 1'b1); add(3, 8'h73, 1'b1);
    run_model();
    drain("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
